// File: rtl/sfft_pkg.sv
// Shared definitions for the stochastic FFT bitstream decoder: FSM encodings,
// output word width helper and the per-channel packing slice macro.
`ifndef SFFT_PKG_SV
`define SFFT_PKG_SV

`define SFFT_CH(k, w) ((k)*(w)) +: (w)

package sfft_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        DONE  = ST_DONE
    } state_e;

    // Room for the full count WINDOW plus a sign bit for bipolar words.
    function automatic int ow_f(input int bw);
        return bw + 2;
    endfunction

endpackage

`endif

// File: rtl/sfft_ones_counter.sv
// Per-channel ones counter; counts set bits on enabled cycles, range 0..2**BITWIDTH.
module sfft_ones_counter
    import sfft_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic              iClk,
    input  logic              iClr,
    input  logic              iEn,
    input  logic              iBit,
    output logic [BITWIDTH:0] oCount
);

    localparam int CW = BITWIDTH + 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (iClr) begin
            count_d = '0;
        end else if (iEn) begin
            count_d = count_q + CW'(iBit);
        end
    end

    always_ff @(posedge iClk) begin
        count_q <= count_d;
    end

    assign oCount = count_q;

endmodule

// File: rtl/sfft_bitstream_decoder.sv
// Windowed unary-to-binary decoder for the stochastic FFT outputs.
// Define SFFT_DEC_BIPOLAR_EN to emit signed bipolar words (2*count - WINDOW).
module sfft_bitstream_decoder
    import sfft_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 8,
    parameter int WINDOW    = 2**BITWIDTH,
    parameter int OW        = ow_f(BITWIDTH)
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iEn,
    input  logic                    iClr,
    input  logic                    iStart,
    input  logic [NUMINPUTS-1:0]    iReal,
    input  logic [NUMINPUTS-1:0]    iImg,
    input  logic                    iReady,
    output logic                    oValid,
    output logic                    oBusy,
    output logic [NUMINPUTS*OW-1:0] oReal,
    output logic [NUMINPUTS*OW-1:0] oImg
);

    localparam int CW = BITWIDTH + 1;

    state_e                  state_q, state_d;
    logic [CW-1:0]           smp_q, smp_d;
    logic [NUMINPUTS*OW-1:0] real_q, real_d;
    logic [NUMINPUTS*OW-1:0] img_q, img_d;
    logic [CW-1:0]           real_cnt [NUMINPUTS];
    logic [CW-1:0]           img_cnt  [NUMINPUTS];

    logic in_accum;
    logic last_smp;
    logic restart;
    logic cnt_clr;
    logic cnt_en;

`ifdef SFFT_DEC_BIPOLAR_EN
    localparam logic signed [OW-1:0] WIN_S = OW'(WINDOW);

    function automatic logic [OW-1:0] conv_f(input logic [CW-1:0] c);
        logic signed [OW-1:0] dbl;
        dbl = $signed(OW'({c, 1'b0}));
        return dbl - WIN_S;
    endfunction
`else
    function automatic logic [OW-1:0] conv_f(input logic [CW-1:0] c);
        return OW'(c);
    endfunction
`endif

    assign in_accum = (state_q == ACCUM);
    assign cnt_en   = in_accum && iEn;
    // The final sample is still on the inputs; it is folded in at load time.
    assign last_smp = cnt_en && !iClr && (smp_q == CW'(WINDOW - 1));
    assign restart  = iStart && ((state_q == IDLE) || ((state_q == DONE) && iReady));
    assign cnt_clr  = iRst || iClr || restart;

    for (genvar k = 0; k < NUMINPUTS; k++) begin : g_ch
        sfft_ones_counter #(.BITWIDTH(BITWIDTH)) u_re (
            .iClk   (iClk),
            .iClr   (cnt_clr),
            .iEn    (cnt_en),
            .iBit   (iReal[k]),
            .oCount (real_cnt[k])
        );
        sfft_ones_counter #(.BITWIDTH(BITWIDTH)) u_im (
            .iClk   (iClk),
            .iClr   (cnt_clr),
            .iEn    (cnt_en),
            .iBit   (iImg[k]),
            .oCount (img_cnt[k])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iStart) state_d = ACCUM;
            ACCUM:   if (last_smp) state_d = DONE;
            DONE:    if (iReady) state_d = iStart ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
        if (iClr) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        smp_d = smp_q;
        if (iClr || restart) begin
            smp_d = '0;
        end else if (cnt_en) begin
            smp_d = smp_q + CW'(1);
        end
    end

    always_comb begin
        real_d = real_q;
        img_d  = img_q;
        if (last_smp) begin
            for (int k = 0; k < NUMINPUTS; k++) begin
                real_d[`SFFT_CH(k, OW)] = conv_f(real_cnt[k] + CW'(iReal[k]));
                img_d[`SFFT_CH(k, OW)]  = conv_f(img_cnt[k] + CW'(iImg[k]));
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            smp_q   <= '0;
            real_q  <= '0;
            img_q   <= '0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            real_q  <= real_d;
            img_q   <= img_d;
        end
    end

    assign oValid = (state_q == DONE);
    assign oBusy  = in_accum;
    assign oReal  = real_q;
    assign oImg   = img_q;

endmodule

// File: tb/tb_sfft_bitstream_decoder.sv
// Randomized bench for sfft_bitstream_decoder at BITWIDTH=4, NUMINPUTS=8.
module tb_sfft_bitstream_decoder;

    localparam int BW  = 4;
    localparam int NI  = 8;
    localparam int WIN = 16;
    localparam int OWT = BW + 2;

    logic            iClk;
    logic            iRst;
    logic            iEn;
    logic            iClr;
    logic            iStart;
    logic [NI-1:0]   iReal;
    logic [NI-1:0]   iImg;
    logic            iReady;
    logic            oValid;
    logic            oBusy;
    logic [NI*OWT-1:0] oReal;
    logic [NI*OWT-1:0] oImg;

    int n_chk;
    int n_err;
    logic [NI*OWT-1:0] exp_r;
    logic [NI*OWT-1:0] exp_i;

    sfft_bitstream_decoder #(
        .BITWIDTH  (BW),
        .NUMINPUTS (NI),
        .WINDOW    (WIN)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iClr   (iClr),
        .iStart (iStart),
        .iReal  (iReal),
        .iImg   (iImg),
        .iReady (iReady),
        .oValid (oValid),
        .oBusy  (oBusy),
        .oReal  (oReal),
        .oImg   (oImg)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [OWT-1:0] exp_word(input int c);
`ifdef SFFT_DEC_BIPOLAR_EN
        return OWT'(2 * c - WIN);
`else
        return OWT'(c);
`endif
    endfunction

    // Stimulus for enabled sample number s: mode 0 solid, mode 1 density k/8, mode 2 random.
    task automatic gen_bits(input int mode, input int s, output logic [NI-1:0] r, output logic [NI-1:0] i);
        r = '0;
        i = '0;
        case (mode)
            0: begin r = '1; i = '0; end
            1: for (int k = 0; k < NI; k++) begin
                   r[k] = ((s % 8) < k);
                   i[k] = ((s % 8) < (8 - k));
               end
            default: begin r = NI'($urandom); i = NI'($urandom); end
        endcase
    endtask

    task automatic run_window(input int bitmode, input int enmode, input bit started);
        int sr [NI];
        int si [NI];
        int nen;
        int cyc;
        bit en;
        logic [NI-1:0] r, i;
        nen = 0;
        cyc = 0;
        for (int k = 0; k < NI; k++) begin sr[k] = 0; si[k] = 0; end
        if (!started) begin
            iStart = 1'b1;
            tick();
        end
        iStart = 1'b0;
        chk("busy_at_start", oBusy, 1);
        chk("valid_at_start", oValid, 0);
        while (nen < WIN && cyc < 400) begin
            case (enmode)
                0: en = 1'b1;
                1: en = (cyc % 2 == 1);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            if (en) gen_bits(bitmode, nen, r, i);
            else begin r = NI'($urandom); i = NI'($urandom); end
            iEn = en;
            iReal = r;
            iImg = i;
            iStart = 1'($urandom_range(0, 1));
            if (en) begin
                for (int k = 0; k < NI; k++) begin
                    sr[k] += int'(r[k]);
                    si[k] += int'(i[k]);
                end
                nen++;
            end
            tick();
            cyc++;
            if (nen < WIN) chk("valid_early", oValid, 0);
        end
        iEn = 1'b0;
        iStart = 1'b0;
        chk("window_complete", nen, WIN);
        if (enmode == 1) chk("toggle_len", cyc, 32);
        for (int k = 0; k < NI; k++) begin
            exp_r[k*OWT +: OWT] = exp_word(sr[k]);
            exp_i[k*OWT +: OWT] = exp_word(si[k]);
        end
        chk("valid_done", oValid, 1);
        chk("busy_done", oBusy, 0);
        chk("real_words", oReal, exp_r);
        chk("imag_words", oImg, exp_i);
    endtask

    task automatic finish_window(input int wait_n, input bit next_start);
        for (int n = 0; n < wait_n; n++) begin
            iReady = 1'b0;
            iStart = 1'($urandom_range(0, 1));
            tick();
            chk("hold_valid", oValid, 1);
            chk("hold_real", oReal, exp_r);
            chk("hold_imag", oImg, exp_i);
        end
        iStart = next_start;
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        iStart = 1'b0;
        chk("hs_valid", oValid, 0);
        chk("hs_busy", oBusy, next_start);
        chk("hs_real_kept", oReal, exp_r);
    endtask

    initial begin
        bit ns;
        n_chk = 0;
        n_err = 0;
        iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iStart = 1'b0;
        iReal = '0; iImg = '0; iReady = 1'b0;
        exp_r = '0; exp_i = '0;
        tick();
        tick();
        chk("rst_valid", oValid, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_real", oReal, 0);
        chk("rst_imag", oImg, 0);
        iRst = 1'b0;

        // Samples in IDLE must not leak into the next window.
        for (int n = 0; n < 3; n++) begin
            iEn = 1'b1; iReal = '1; iImg = '1;
            tick();
            chk("idle_busy", oBusy, 0);
            chk("idle_valid", oValid, 0);
        end
        iEn = 1'b0;

        run_window(0, 0, 0);
        finish_window(5, 1);
        run_window(1, 0, 1);
        finish_window(0, 0);
        run_window(2, 1, 0);
        finish_window(2, 0);

        // Abort at the seventh sample.
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int n = 0; n < 6; n++) begin
            iEn = 1'b1; iReal = '1; iImg = '1;
            tick();
        end
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        chk("clr_busy", oBusy, 0);
        chk("clr_valid", oValid, 0);
        chk("clr_real_kept", oReal, exp_r);
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("clr_no_valid", oValid, 0);
        end
        iEn = 1'b0;
        run_window(0, 0, 0);
        finish_window(1, 0);

        // Reset while accumulating.
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int n = 0; n < 5; n++) begin
            iEn = 1'b1; iReal = NI'($urandom); iImg = NI'($urandom);
            tick();
        end
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        iEn = 1'b0;
        chk("rstacc_busy", oBusy, 0);
        chk("rstacc_valid", oValid, 0);
        chk("rstacc_real", oReal, 0);
        chk("rstacc_imag", oImg, 0);
        tick();
        chk("rstacc_idle", oBusy, 0);

        // Reset together with clear while results are pending.
        run_window(0, 2, 0);
        iRst = 1'b1; iClr = 1'b1;
        tick();
        iRst = 1'b0; iClr = 1'b0;
        chk("rstdone_valid", oValid, 0);
        chk("rstdone_busy", oBusy, 0);
        chk("rstdone_real", oReal, 0);
        chk("rstdone_imag", oImg, 0);

        ns = 1'b0;
        for (int w = 0; w < 6; w++) begin
            run_window(2, int'($urandom_range(0, 2)), ns);
            ns = (w == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            finish_window(int'($urandom_range(0, 3)), ns);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
